// File: rtl/span_pkg.sv
// Shared definitions for the SPAN margin pipeline stages: default widths,
// the total-stage state encoding and a saturating adder.
package span_pkg;

  localparam int SPAN_CHARGE_W = 16;
  localparam int SPAN_TOTAL_W  = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FINAL   = 2'd2,
    HOLD    = 2'd3
  } span_state_t;

  // Unsigned add that clamps at all-ones instead of wrapping.
  function automatic logic [SPAN_TOTAL_W-1:0] sat_add(
    input logic [SPAN_TOTAL_W-1:0] a,
    input logic [SPAN_TOTAL_W-1:0] b
  );
    logic [SPAN_TOTAL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SPAN_TOTAL_W] ? {SPAN_TOTAL_W{1'b1}} : s[SPAN_TOTAL_W-1:0];
  endfunction

endpackage

// File: rtl/span_margin_total_if.sv
// Credit stream (in) and final margin result (out) handshakes of the
// SPAN total stage. The block itself sits on the slave side.
interface span_margin_total_if #(
  parameter int CHARGE_W = span_pkg::SPAN_CHARGE_W,
  parameter int TOTAL_W  = span_pkg::SPAN_TOTAL_W
);

  logic                credit_valid;
  logic [CHARGE_W-1:0] credit;
  logic                credit_ready;

  logic                total_valid;
  logic                total_ready;
  logic [TOTAL_W-1:0]  total;
  logic [TOTAL_W-1:0]  creditApplied;
  logic                floored;

  modport master (
    output credit_valid, credit, total_ready,
    input  credit_ready, total_valid, total, creditApplied, floored
  );

  modport slave (
    input  credit_valid, credit, total_ready,
    output credit_ready, total_valid, total, creditApplied, floored
  );

endinterface

// File: rtl/span_margin_total.sv
// Final SPAN stage: base = scan risk + spread charge, minus the summed
// cross-commodity credits (never below zero), then raised to the
// short-option minimum. One result per portfolio via valid/ready.
module span_margin_total
  import span_pkg::*;
#(
  parameter int CHARGE_W = SPAN_CHARGE_W,
  parameter int TOTAL_W  = SPAN_TOTAL_W,
  parameter int MAX_LEGS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [TOTAL_W-1:0] scanRisk,
  input  logic [TOTAL_W-1:0] spreadCharge,
  input  logic [TOTAL_W-1:0] minCharge,
  input  logic [3:0]         numLegs,
  output logic               busy,
  span_margin_total_if.slave bus
);

  span_state_t state_reg, state_next;

  logic [TOTAL_W-1:0] base_reg, min_reg, sum_reg;
  logic [TOTAL_W-1:0] total_reg, applied_reg;
  logic               floored_reg;
  logic [3:0]         remaining_reg;

  logic [CHARGE_W-1:0] credit_in;
  logic [3:0]          legs_clamped;
  logic [TOTAL_W-1:0]  net;
  logic                credit_take;
  logic                ready_c, busy_c, valid_c;

  assign credit_in    = bus.credit;
  assign legs_clamped = (numLegs > 4'(MAX_LEGS)) ? 4'(MAX_LEGS) : numLegs;
  assign credit_take  = (state_reg == COLLECT) && bus.credit_valid;
  assign net          = (base_reg > sum_reg) ? (base_reg - sum_reg) : '0;

  // State register; reset abandons any portfolio in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake outputs, decoded from the current state.
  always_comb begin
    state_next = state_reg;
    ready_c    = 1'b0;
    busy_c     = 1'b1;
    valid_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        busy_c = 1'b0;
        if (start) state_next = (legs_clamped == 4'd0) ? FINAL : COLLECT;
      end
      COLLECT: begin
        ready_c = 1'b1;
        if (credit_take && remaining_reg == 4'd1) state_next = FINAL;
      end
      FINAL: state_next = HOLD;
      HOLD: begin
        valid_c = 1'b1;
        if (bus.total_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Portfolio operands: latched on start, credits accumulated in COLLECT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_reg      <= '0;
      min_reg       <= '0;
      sum_reg       <= '0;
      remaining_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      base_reg      <= sat_add(scanRisk, spreadCharge);
      min_reg       <= minCharge;
      sum_reg       <= '0;
      remaining_reg <= legs_clamped;
    end else if (credit_take) begin
      sum_reg       <= sat_add(sum_reg, TOTAL_W'(credit_in));
      remaining_reg <= remaining_reg - 4'd1;
    end
  end

  // Result registers: written only in FINAL so they stay stable through
  // HOLD and afterwards until the next portfolio finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_reg   <= '0;
      applied_reg <= '0;
      floored_reg <= 1'b0;
    end else if (state_reg == FINAL) begin
      total_reg   <= (net < min_reg) ? min_reg : net;
      floored_reg <= (net < min_reg);
      applied_reg <= (sum_reg < base_reg) ? sum_reg : base_reg;
    end
  end

  assign busy              = busy_c;
  assign bus.credit_ready  = ready_c;
  assign bus.total_valid   = valid_c;
  assign bus.total         = total_reg;
  assign bus.creditApplied = applied_reg;
  assign bus.floored       = floored_reg;

endmodule

// File: tb/tb_span_margin_total.sv
// Bench for span_margin_total: directed scenarios plus random portfolios,
// each compared against an arithmetic model of the margin rules.
module tb_span_margin_total;

  localparam int     MAX_LEGS = 8;
  localparam longint MAXV     = 64'hFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [23:0] scanRisk = '0, spreadCharge = '0, minCharge = '0;
  logic [3:0]  numLegs = '0;
  logic        busy;

  int errors = 0;
  int checks = 0;
  longint cred_q[$];

  span_margin_total_if #(.CHARGE_W(16), .TOTAL_W(24)) bus ();

  span_margin_total #(.CHARGE_W(16), .TOTAL_W(24), .MAX_LEGS(MAX_LEGS)) dut (
    .clk(clk), .reset(reset), .start(start),
    .scanRisk(scanRisk), .spreadCharge(spreadCharge), .minCharge(minCharge),
    .numLegs(numLegs), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One complete portfolio; credits come from cred_q.
  task automatic run_portfolio(input string name, input longint scan, input longint spread,
                               input longint minc, input int legs, input int gap_lo,
                               input int gap_hi, input int bp);
    int n_exp, accepted, idx, cyc, last, gap;
    longint base, sum, net, e_total, e_app, e_fl;
    bit ready_seen;
    n_exp = (legs > MAX_LEGS) ? MAX_LEGS : legs;
    base = scan + spread;
    if (base > MAXV) base = MAXV;
    sum = 0;
    for (int i = 0; i < n_exp; i++) sum += cred_q[i];
    if (sum > MAXV) sum = MAXV;
    net     = (base > sum) ? base - sum : 0;
    e_total = (net > minc) ? net : minc;
    e_fl    = (net < minc) ? 1 : 0;
    e_app   = (sum < base) ? sum : base;

    @(negedge clk);
    check_value({name, ".idle_busy"}, longint'(busy), 0);
    start = 1'b1; scanRisk = 24'(scan); spreadCharge = 24'(spread);
    minCharge = 24'(minc); numLegs = 4'(legs);
    @(negedge clk);
    start = 1'b0; scanRisk = 24'($urandom); spreadCharge = 24'($urandom);
    minCharge = 24'($urandom); numLegs = 4'($urandom);
    check_value({name, ".busy"}, longint'(busy), 1);

    cyc = 1; last = 0; accepted = 0; idx = 0; gap = 0;
    while (accepted < n_exp && cyc < 400) begin
      if (gap == 0) begin
        bus.credit_valid = 1'b1;
        bus.credit = 16'(cred_q[idx]);
        if (bus.credit_ready) begin
          accepted++; idx++; last = cyc;
          gap = $urandom_range(gap_hi, gap_lo);
        end
      end else begin
        bus.credit_valid = 1'b0;
        gap--;
      end
      @(negedge clk); cyc++;
    end
    check_value({name, ".accepted"}, accepted, n_exp);

    // A credit offered after the last one must be left unconsumed.
    bus.credit_valid = 1'b1;
    bus.credit = 16'hABCD;
    ready_seen = 1'b0;
    while (!bus.total_valid && cyc < last + 20) begin
      if (bus.credit_ready) ready_seen = 1'b1;
      @(negedge clk); cyc++;
    end
    bus.credit_valid = 1'b0;
    check_value({name, ".total_valid"}, longint'(bus.total_valid), 1);
    check_value({name, ".latency"}, cyc - last, 2);
    check_value({name, ".no_extra_ready"}, longint'(ready_seen), 0);

    for (int i = 0; i < bp; i++) begin
      if (i == 0) begin
        start = 1'b1; scanRisk = 24'd7; spreadCharge = 24'd7;
        minCharge = 24'd9999; numLegs = 4'd0;
      end else begin
        start = 1'b0;
      end
      check_value({name, ".bp_total"}, longint'(bus.total), e_total);
      check_value({name, ".bp_busy"}, longint'(busy), 1);
      check_value({name, ".bp_valid"}, longint'(bus.total_valid), 1);
      @(negedge clk);
    end
    start = 1'b0;
    check_value({name, ".total"}, longint'(bus.total), e_total);
    check_value({name, ".applied"}, longint'(bus.creditApplied), e_app);
    check_value({name, ".floored"}, longint'(bus.floored), e_fl);
    bus.total_ready = 1'b1;
    @(negedge clk);
    bus.total_ready = 1'b0;
    check_value({name, ".valid_drop"}, longint'(bus.total_valid), 0);
    check_value({name, ".idle"}, longint'(busy), 0);
    check_value({name, ".held_total"}, longint'(bus.total), e_total);
    $display("%s: scan=%0d spread=%0d min=%0d legs=%0d total=%0d applied=%0d floored=%0d",
             name, scan, spread, minc, legs, bus.total, bus.creditApplied, bus.floored);
  endtask

  initial begin
    bus.credit_valid = 1'b0;
    bus.credit = '0;
    bus.total_ready = 1'b0;

    #1;
    check_value("reset.busy", longint'(busy), 0);
    check_value("reset.credit_ready", longint'(bus.credit_ready), 0);
    check_value("reset.total_valid", longint'(bus.total_valid), 0);
    check_value("reset.total", longint'(bus.total), 0);
    check_value("reset.applied", longint'(bus.creditApplied), 0);
    check_value("reset.floored", longint'(bus.floored), 0);
    // A credit offered while idle must not be taken.
    bus.credit_valid = 1'b1; bus.credit = 16'd999;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_value("idle.credit_ready", longint'(bus.credit_ready), 0);
    bus.credit_valid = 1'b0;

    cred_q = '{300, 150};
    run_portfolio("basic", 1000, 200, 0, 2, 0, 0, 0);

    cred_q = '{};
    run_portfolio("zero_legs", 500, 0, 100, 0, 0, 0, 0);

    cred_q = '{300, 300};
    run_portfolio("over_credit", 400, 0, 50, 2, 0, 0, 0);

    cred_q = '{300, 150};
    run_portfolio("backpressure", 1000, 200, 0, 2, 2, 2, 5);

    // Reset in the middle of a portfolio, after one credit is taken.
    @(negedge clk);
    start = 1'b1; scanRisk = 24'd5000; spreadCharge = 24'd0;
    minCharge = 24'd0; numLegs = 4'd3;
    @(negedge clk);
    start = 1'b0;
    bus.credit_valid = 1'b1; bus.credit = 16'd100;
    @(negedge clk);
    bus.credit_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_value("midreset.busy", longint'(busy), 0);
    check_value("midreset.credit_ready", longint'(bus.credit_ready), 0);
    check_value("midreset.total_valid", longint'(bus.total_valid), 0);
    check_value("midreset.total", longint'(bus.total), 0);
    check_value("midreset.applied", longint'(bus.creditApplied), 0);
    check_value("midreset.floored", longint'(bus.floored), 0);
    $display("midreset: busy=%0d total=%0d", busy, bus.total);
    @(negedge clk);
    reset = 1'b1;

    cred_q = '{300, 150};
    run_portfolio("after_reset", 1000, 200, 0, 2, 0, 1, 0);

    cred_q = '{};
    for (int i = 0; i < 12; i++) cred_q.push_back(1);
    run_portfolio("saturate", 64'hFFFFF0, 64'h20, 0, 12, 0, 0, 1);

    for (int r = 0; r < 10; r++) begin
      int legs;
      longint scan, spread, minc;
      legs   = $urandom_range(10, 0);
      scan   = ($urandom_range(3, 0) == 0) ? longint'($urandom_range(24'hFFFFFF, 24'hF00000))
                                           : longint'($urandom_range(300000, 0));
      spread = longint'($urandom_range(100000, 0));
      minc   = ($urandom_range(1, 0) == 1) ? longint'($urandom_range(400000, 0)) : 0;
      cred_q = '{};
      for (int i = 0; i < legs; i++) cred_q.push_back(longint'($urandom_range(16'hFFFF, 0)));
      run_portfolio($sformatf("random%0d", r), scan, spread, minc, legs, 0, 2,
                    $urandom_range(3, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
